// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGES carry-chain chunks.
// Each stage adds one chunk. The carry out of a chunk is registered and feeds
// the next chunk. Unprocessed operand chunks, completed result chunks and the
// sub flag travel down the pipe with their operation, so every bit of a result
// reaches the output in the same cycle. A valid/ready handshake stalls the
// whole pipe at once.
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 a,
  input  logic [WIDTH-1:0]                 b,
  input  logic                             sub,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH:0]                   sum,
  output logic [$clog2(STAGES+1)-1:0]      count
);

  localparam int C    = WIDTH / STAGES;
  localparam int CW   = $clog2(STAGES + 1);
  localparam int LAST = STAGES - 1;

  logic              stall;
  logic              in_xfer;
  logic              out_xfer;
  logic [WIDTH-1:0]  b_eff;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cry_q, cry_d;
  logic [STAGES-1:0] sub_q, sub_d;
  logic [WIDTH-1:0]  opa_q [STAGES];
  logic [WIDTH-1:0]  opa_d [STAGES];
  logic [WIDTH-1:0]  opb_q [STAGES];
  logic [WIDTH-1:0]  opb_d [STAGES];
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];
  logic [C:0]        part  [STAGES];
  logic [CW-1:0]     count_q, count_d;

  // The pipe freezes only when the result it is showing cannot leave.
  assign out_valid = vld_q[LAST];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !out_valid || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign count     = count_q;

  // A subtract leaves the chain with carry = !borrow. Flipping it with the
  // delayed sub flag gives bit WIDTH = (a < b).
  assign sum = {cry_q[LAST] ^ sub_q[LAST], res_q[LAST]};

  // Per-stage chunk adders and the stage advance.
  // Subtract is a + ~b + 1: b is inverted on entry and sub is the stage-0 carry-in.
  always_comb begin
    b_eff = sub ? ~b : b;
    vld_d = vld_q;
    cry_d = cry_q;
    sub_d = sub_q;
    for (int k = 0; k < STAGES; k++) begin
      opa_d[k] = opa_q[k];
      opb_d[k] = opb_q[k];
      res_d[k] = res_q[k];
      part[k]  = '0;
    end

    part[0] = {1'b0, a[C-1:0]} + {1'b0, b_eff[C-1:0]} + {{C{1'b0}}, sub};
    for (int k = 1; k < STAGES; k++) begin
      part[k] = {1'b0, opa_q[k-1][k*C +: C]} + {1'b0, opb_q[k-1][k*C +: C]}
              + {{C{1'b0}}, cry_q[k-1]};
    end

    if (!stall) begin
      vld_d[0]          = in_valid;
      opa_d[0]          = a;
      opb_d[0]          = b_eff;
      sub_d[0]          = sub;
      cry_d[0]          = part[0][C];
      res_d[0]          = '0;
      res_d[0][C-1:0]   = part[0][C-1:0];
      for (int k = 1; k < STAGES; k++) begin
        vld_d[k]           = vld_q[k-1];
        opa_d[k]           = opa_q[k-1];
        opb_d[k]           = opb_q[k-1];
        sub_d[k]           = sub_q[k-1];
        cry_d[k]           = part[k][C];
        res_d[k]           = res_q[k-1];
        res_d[k][k*C +: C] = part[k][C-1:0];
      end
    end
  end

  // Occupancy counter: up on an accept alone, down on a delivery alone.
  always_comb begin
    count_d = count_q;
    if (in_xfer && !out_xfer) begin
      count_d = count_q + CW'(1);
    end else if (!in_xfer && out_xfer) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pipeline registers. Reset flushes every in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      cry_q   <= '0;
      sub_q   <= '0;
      count_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        res_q[k] <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      cry_q   <= cry_d;
      sub_q   <= sub_d;
      count_q <= count_d;
      for (int k = 0; k < STAGES; k++) begin
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
        res_q[k] <= res_d[k];
      end
    end
  end

endmodule
